// File: rtl/router_pkg.sv
// Shared types for the router output-port arbitration logic.
package router_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] prio_t;
    typedef logic [1:0] port_id_t;
    typedef logic [3:0] burst_cnt_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/port_arbiter_if.sv
// Request/grant bundle between the input FIFOs, the output-port mux and the arbiter.
interface port_arbiter_if;

    logic [2*router_pkg::NUM_PORTS-1:0] prio_val;
    logic                               prio_wr;
    logic [router_pkg::NUM_PORTS-1:0]   req;
    logic                               dst_rdy;
    logic [router_pkg::NUM_PORTS-1:0]   gnt;
    logic                               gnt_vld;
    router_pkg::port_id_t               gnt_id;
    logic                               beat;

    // Requester/configuration side.
    modport master (
        output prio_val, prio_wr, req, dst_rdy,
        input  gnt, gnt_vld, gnt_id, beat
    );

    // Arbiter side.
    modport slave (
        input  prio_val, prio_wr, req, dst_rdy,
        output gnt, gnt_vld, gnt_id, beat
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: highest priority first, round-robin among ties.
module arb_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  prio_t                prio [NUM_PORTS],
    input  port_id_t             last_id,
    output logic                 pick_vld,
    output port_id_t             pick_id
);

    prio_t    max_prio;
    port_id_t idx;

    // Highest priority value among the active requests.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        max_prio = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end
    end

    // First max-priority requester found scanning upward from last_id+1.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = last_id;
        idx      = last_id;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = last_id + port_id_t'(k);
            if (!pick_vld && req[idx] && (prio[idx] == max_prio)) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Priority-weighted round-robin arbiter for one router output port with bounded bursts.
module port_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    port_arbiter_if.slave bus
);

    localparam burst_cnt_t           BURST_LIMIT = burst_cnt_t'(MAX_BURST);
    localparam logic [NUM_REQ-1:0]   GNT_BASE    = NUM_REQ'(1);

    arb_state_e           state_q,   state_d;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    port_id_t             gnt_id_q,  gnt_id_d;
    port_id_t             last_id_q, last_id_d;
    burst_cnt_t           cnt_q,     cnt_d;
    logic [7:0]           prio_q,    prio_d;

    prio_t                prio_arr [NUM_PORTS];
    logic                 pick_vld;
    port_id_t             pick_id;
    logic                 gnt_vld;
    logic                 owner_req;
    logic                 beat;
    logic                 last_beat;
    burst_cnt_t           cnt_inc;

    // Split the registered priority word into per-requester fields.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            prio_arr[i] = prio_q[2*i +: 2];
        end
    end

    // One picker serves both the IDLE grant and the release re-grant; a
    // requester that dropped req is excluded simply by its req being low.
    arb_pick u_pick (
        .req      (bus.req),
        .prio     (prio_arr),
        .last_id  (last_id_q),
        .pick_vld (pick_vld),
        .pick_id  (pick_id)
    );

    // Transfer strobe and burst-end detection.
    always_comb begin
        gnt_vld   = |gnt_q;
        owner_req = bus.req[gnt_id_q];
        beat      = gnt_vld && owner_req && bus.dst_rdy;
        cnt_inc   = cnt_q + burst_cnt_t'(1);
        last_beat = beat && (cnt_inc == BURST_LIMIT);
    end

    // Priority register load; arbitration only ever sees the registered copy.
    always_comb begin
        prio_d = bus.prio_wr ? bus.prio_val : prio_q;
    end

    // Next-state logic: grant on request in IDLE, count beats and re-arbitrate in GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_d     = GNT_BASE << pick_id;
                    gnt_id_d  = pick_id;
                    last_id_d = pick_id;
                    cnt_d     = '0;
                    state_d   = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_req || last_beat) begin
                    cnt_d = '0;
                    if (pick_vld) begin
                        // Back-to-back hand-over, possibly to the same owner.
                        gnt_d     = GNT_BASE << pick_id;
                        gnt_id_d  = pick_id;
                        last_id_d = pick_id;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_id_q <= port_id_t'(NUM_PORTS - 1);
            cnt_q     <= '0;
            prio_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = gnt_vld;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.beat    = beat;

endmodule
